// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use / memory-wait hazard unit.
package hazard_pkg;

  localparam int ADDR_W_DEF = 4;

  localparam logic [3:0] REG_ZERO     = 4'b0000;
  localparam logic       MEM2REG_LOAD = 1'b0;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } hz_state_t;

  // Pipeline-register controls produced in one cycle.
  typedef struct packed {
    logic stall_pc;
    logic stall_ifid;
    logic bubble_idex;
    logic freeze_mem;
  } hz_ctl_t;

  localparam hz_ctl_t CTL_NONE = '0;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with synchronous active-low reset, sync clear and enable.
module hazard_sat_counter #(
  parameter int unsigned   W   = 8,
  parameter logic [W-1:0]  MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Clear wins over enable so a clear on a busy cycle still lands at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use hazard detection and data-memory wait freeze with watchdog.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WAIT_MAX    = 255,
  parameter int WAIT_CNT_W  = 8,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [ADDR_W-1:0]      id_rs,
  input  logic [ADDR_W-1:0]      id_rt,
  input  logic [ADDR_W-1:0]      id_rd,
  input  logic                   id_use_rs,
  input  logic                   id_use_rt,
  input  logic                   id_is_store,
  input  logic                   idex_rf_wen,
  input  logic                   idex_mem2reg,
  input  logic [ADDR_W-1:0]      idex_waddr,
  input  logic                   dmem_req,
  input  logic                   dmem_ready,
  output logic                   stall_pc,
  output logic                   stall_ifid,
  output logic                   bubble_idex,
  output logic                   freeze_mem,
  output logic                   mem_timeout,
  output logic                   fsm_state,
  input  logic                   perf_clr,
  output logic [STALL_CNT_W-1:0] load_stall_cnt,
  output logic [STALL_CNT_W-1:0] mem_wait_cnt
);

  // Handshake: dmem_req marks an access in EX/MEM; the access completes on the
  // first cycle dmem_ready is high, and every cycle before that is a wait cycle.

  logic                  lu;
  logic                  mw;
  logic                  src_hit;
  hz_state_t             state_q;
  hz_state_t             state_d;
  hz_ctl_t               ctl;
  logic                  wait_clr;
  logic                  wait_en;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  timeout_q;

  // Register zero is hard-wired, so a write to it never creates a hazard.
  assign src_hit = (id_use_rs   && (id_rs == idex_waddr)) ||
                   (id_use_rt   && (id_rt == idex_waddr)) ||
                   (id_is_store && (id_rd == idex_waddr));

  assign lu = id_valid && idex_rf_wen && (idex_mem2reg == MEM2REG_LOAD) &&
              (idex_waddr != ADDR_W'(REG_ZERO)) && src_hit;

  assign mw = dmem_req && !dmem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (mw)         state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: if (dmem_ready) state_d = ST_RUN;
      default:                     state_d = ST_RUN;
    endcase
  end

  // Memory wait has priority; a load-use bubble is only issued once the
  // pipeline is free to move.
  always_comb begin
    ctl = CTL_NONE;
    case (state_q)
      ST_RUN: begin
        if (mw) begin
          ctl.freeze_mem = 1'b1;
          ctl.stall_pc   = 1'b1;
          ctl.stall_ifid = 1'b1;
        end else if (lu) begin
          ctl.stall_pc    = 1'b1;
          ctl.stall_ifid  = 1'b1;
          ctl.bubble_idex = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready) begin
          ctl.freeze_mem = 1'b1;
          ctl.stall_pc   = 1'b1;
          ctl.stall_ifid = 1'b1;
        end else if (lu) begin
          ctl.stall_pc    = 1'b1;
          ctl.stall_ifid  = 1'b1;
          ctl.bubble_idex = 1'b1;
        end
      end
      default: ctl = CTL_NONE;
    endcase
  end

  assign wait_clr = (state_q == ST_RUN) && mw;
  assign wait_en  = (state_q == ST_MEM_WAIT);

  hazard_sat_counter #(
    .W   (WAIT_CNT_W),
    .MAX (WAIT_CNT_W'(WAIT_MAX))
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wait_clr),
    .en    (wait_en),
    .count (wait_cnt)
  );

  // Sets on the same edge the counter reaches WAIT_MAX; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (wait_en && (wait_cnt >= WAIT_CNT_W'(WAIT_MAX - 1))) begin
      timeout_q <= 1'b1;
    end
  end

  assign stall_pc    = rst_n && ctl.stall_pc;
  assign stall_ifid  = rst_n && ctl.stall_ifid;
  assign bubble_idex = rst_n && ctl.bubble_idex;
  assign freeze_mem  = rst_n && ctl.freeze_mem;
  assign mem_timeout = rst_n && timeout_q;
  assign fsm_state   = rst_n && (state_q == ST_MEM_WAIT);

`ifdef HAZARD_PERF_CNT_EN
  logic [STALL_CNT_W-1:0] load_stall_q;
  logic [STALL_CNT_W-1:0] mem_wait_q;

  hazard_sat_counter #(
    .W (STALL_CNT_W)
  ) u_load_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .en    (ctl.bubble_idex),
    .count (load_stall_q)
  );

  hazard_sat_counter #(
    .W (STALL_CNT_W)
  ) u_mem_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .en    (ctl.freeze_mem),
    .count (mem_wait_q)
  );

  assign load_stall_cnt = rst_n ? load_stall_q : '0;
  assign mem_wait_cnt   = rst_n ? mem_wait_q   : '0;
`else
  logic unused_perf_clr;

  assign unused_perf_clr = perf_clr;
  assign load_stall_cnt  = '0;
  assign mem_wait_cnt    = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench for hazard_stall_unit: load-use, memory wait, watchdog, reset.
module tb_hazard_stall_unit;

  localparam int ADDR_W      = 4;
  localparam int WAIT_MAX    = 255;
  localparam int STALL_CNT_W = 16;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   id_valid;
  logic [ADDR_W-1:0]      id_rs, id_rt, id_rd;
  logic                   id_use_rs, id_use_rt, id_is_store;
  logic                   idex_rf_wen, idex_mem2reg;
  logic [ADDR_W-1:0]      idex_waddr;
  logic                   dmem_req, dmem_ready;
  logic                   stall_pc, stall_ifid, bubble_idex, freeze_mem;
  logic                   mem_timeout, fsm_state;
  logic                   perf_clr;
  logic [STALL_CNT_W-1:0] load_stall_cnt, mem_wait_cnt;

  int n_vec = 0;
  int n_err = 0;

  hazard_stall_unit #(
    .ADDR_W      (ADDR_W),
    .WAIT_MAX    (WAIT_MAX),
    .WAIT_CNT_W  (8),
    .STALL_CNT_W (STALL_CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rd          (id_rd),
    .id_use_rs      (id_use_rs),
    .id_use_rt      (id_use_rt),
    .id_is_store    (id_is_store),
    .idex_rf_wen    (idex_rf_wen),
    .idex_mem2reg   (idex_mem2reg),
    .idex_waddr     (idex_waddr),
    .dmem_req       (dmem_req),
    .dmem_ready     (dmem_ready),
    .stall_pc       (stall_pc),
    .stall_ifid     (stall_ifid),
    .bubble_idex    (bubble_idex),
    .freeze_mem     (freeze_mem),
    .mem_timeout    (mem_timeout),
    .fsm_state      (fsm_state),
    .perf_clr       (perf_clr),
    .load_stall_cnt (load_stall_cnt),
    .mem_wait_cnt   (mem_wait_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic pc, input logic ifid,
                         input logic bub, input logic frz, input logic st);
    #1;
    check({tag, ".stall_pc"},    {31'b0, stall_pc},    {31'b0, pc});
    check({tag, ".stall_ifid"},  {31'b0, stall_ifid},  {31'b0, ifid});
    check({tag, ".bubble_idex"}, {31'b0, bubble_idex}, {31'b0, bub});
    check({tag, ".freeze_mem"},  {31'b0, freeze_mem},  {31'b0, frz});
    check({tag, ".fsm_state"},   {31'b0, fsm_state},   {31'b0, st});
  endtask

  task automatic chk_cnt(input string tag, input int lsc, input int mwc);
    check({tag, ".load_stall_cnt"}, 32'(load_stall_cnt), PERF ? 32'(lsc) : 32'd0);
    check({tag, ".mem_wait_cnt"},   32'(mem_wait_cnt),   PERF ? 32'(mwc) : 32'd0);
  endtask

  // driver tasks
  task automatic clear_inputs();
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_is_store = 1'b0;
    idex_rf_wen = 1'b0; idex_mem2reg = 1'b1; idex_waddr = '0;
    dmem_req = 1'b0; dmem_ready = 1'b0; perf_clr = 1'b0;
  endtask

  task automatic drive_idex(input logic wen, input logic m2r, input logic [ADDR_W-1:0] wa);
    idex_rf_wen = wen; idex_mem2reg = m2r; idex_waddr = wa;
  endtask

  task automatic drive_id(input logic [ADDR_W-1:0] rs, input logic urs,
                          input logic [ADDR_W-1:0] rt, input logic urt,
                          input logic [ADDR_W-1:0] rd, input logic st);
    id_valid = 1'b1; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_rd = rd; id_is_store = st;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    // Reset with a live load-use pattern: outputs must still be forced low.
    drive_idex(1'b1, 1'b0, 4'd5);
    drive_id(4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    cyc();
    chk_ctl("rst", 0, 0, 0, 0, 0);
    check("rst.mem_timeout", {31'b0, mem_timeout}, 32'd0);
    cyc();
    rst_n = 1'b1;
    clear_inputs();
    chk_ctl("post_rst", 0, 0, 0, 0, 0);
    chk_cnt("post_rst", 0, 0);
    cyc();

    // Load r5 in EX, ID reads r5: one bubble, then ID/EX holds the NOP.
    drive_idex(1'b1, 1'b0, 4'd5);
    drive_id(4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    chk_ctl("lu_rs", 1, 1, 1, 0, 0);
    cyc();
    drive_idex(1'b0, 1'b0, 4'd0);
    chk_ctl("lu_rs_next", 0, 0, 0, 0, 0);
    cyc();
    chk_cnt("lu_rs", 1, 0);

    // Non-hazard variants.
    drive_idex(1'b1, 1'b0, 4'd0);
    drive_id(4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1);
    chk_ctl("lu_r0", 0, 0, 0, 0, 0);
    cyc();
    drive_idex(1'b1, 1'b1, 4'd5);
    drive_id(4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    chk_ctl("alu_wb", 0, 0, 0, 0, 0);
    cyc();
    drive_idex(1'b1, 1'b0, 4'd5);
    drive_id(4'd5, 1'b0, 4'd5, 1'b0, 4'd5, 1'b0);
    chk_ctl("no_use", 0, 0, 0, 0, 0);
    cyc();
    id_valid = 1'b0;
    id_use_rs = 1'b1;
    chk_ctl("id_invalid", 0, 0, 0, 0, 0);
    cyc();

    // rt match and store-data match each cost one bubble.
    drive_idex(1'b1, 1'b0, 4'd7);
    drive_id(4'd1, 1'b1, 4'd7, 1'b1, 4'd2, 1'b0);
    chk_ctl("lu_rt", 1, 1, 1, 0, 0);
    cyc();
    drive_idex(1'b1, 1'b0, 4'd3);
    drive_id(4'd1, 1'b0, 4'd2, 1'b0, 4'd3, 1'b1);
    chk_ctl("lu_store", 1, 1, 1, 0, 0);
    cyc();
    clear_inputs();
    chk_ctl("idle", 0, 0, 0, 0, 0);
    cyc();
    chk_cnt("after_lu", 3, 0);

    // Memory wait: entry + 4 wait cycles frozen, lu masked, bubble on ready.
    dmem_req = 1'b1;
    dmem_ready = 1'b0;
    chk_ctl("mw_entry", 1, 1, 0, 1, 0);
    cyc();
    drive_idex(1'b1, 1'b0, 4'd9);
    drive_id(4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk_ctl($sformatf("mw_wait%0d", i), 1, 1, 0, 1, 1);
      cyc();
    end
    dmem_ready = 1'b1;
    chk_ctl("mw_ready", 1, 1, 1, 0, 1);
    cyc();
    dmem_req = 1'b0;
    dmem_ready = 1'b0;
    drive_idex(1'b0, 1'b0, 4'd0);
    chk_ctl("mw_done", 0, 0, 0, 0, 0);
    check("mw.mem_timeout", {31'b0, mem_timeout}, 32'd0);
    cyc();
    chk_cnt("after_mw", 4, 5);

    perf_clr = 1'b1;
    cyc();
    perf_clr = 1'b0;
    chk_cnt("perf_clr", 0, 0);
    clear_inputs();

    // Watchdog: timeout rises after WAIT_MAX wait cycles and stays set.
    dmem_req = 1'b1;
    dmem_ready = 1'b0;
    cyc();
    for (int i = 0; i < WAIT_MAX - 1; i++) cyc();
    check("to.before", {31'b0, mem_timeout}, 32'd0);
    cyc();
    check("to.reached", {31'b0, mem_timeout}, 32'd1);
    chk_ctl("to.still_wait", 1, 1, 0, 1, 1);
    cyc();
    dmem_ready = 1'b1;
    cyc();
    dmem_req = 1'b0;
    dmem_ready = 1'b0;
    chk_ctl("to.released", 0, 0, 0, 0, 0);
    check("to.sticky", {31'b0, mem_timeout}, 32'd1);
    cyc();
    check("to.sticky2", {31'b0, mem_timeout}, 32'd1);

    // Reset in the middle of a wait.
    dmem_req = 1'b1;
    cyc();
    cyc();
    chk_ctl("rw.waiting", 1, 1, 0, 1, 1);
    rst_n = 1'b0;
    chk_ctl("rw.in_reset", 0, 0, 0, 0, 0);
    check("rw.in_reset.timeout", {31'b0, mem_timeout}, 32'd0);
    cyc();
    rst_n = 1'b1;
    dmem_req = 1'b0;
    chk_ctl("rw.after", 0, 0, 0, 0, 0);
    check("rw.after.timeout", {31'b0, mem_timeout}, 32'd0);
    chk_cnt("rw.after", 0, 0);
    cyc();

    // Back-to-back loads: ld r2; ld r4 <- r2; add <- r4.
    drive_idex(1'b1, 1'b0, 4'd2);
    drive_id(4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    chk_ctl("b2b.1", 1, 1, 1, 0, 0);
    cyc();
    drive_idex(1'b0, 1'b0, 4'd0);
    chk_ctl("b2b.2", 0, 0, 0, 0, 0);
    cyc();
    drive_idex(1'b1, 1'b0, 4'd4);
    drive_id(4'd1, 1'b1, 4'd4, 1'b1, 4'd0, 1'b0);
    chk_ctl("b2b.3", 1, 1, 1, 0, 0);
    cyc();
    drive_idex(1'b0, 1'b0, 4'd0);
    chk_ctl("b2b.4", 0, 0, 0, 0, 0);
    cyc();
    chk_cnt("b2b", 2, 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
